// File: rtl/mag_conditioner_pkg.sv
// Shared constants and types for the FFT-magnitude to servo-level conditioner.
package mag_cond_pkg;

  localparam int NBINS = 16;
  localparam int MAG_W = 17;
  localparam int IDX_W = $clog2(NBINS);

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mag_conditioner_if.sv
// Frame-in / levels-out bundle between the FFT magnitude stage and the servo drivers.
interface mag_conditioner_if
  import mag_cond_pkg::*;
  ;

  mag_t       mag_in [0:NBINS-1];
  logic       mag_valid;
  mag_t       level [0:NBINS-1];
  logic       level_valid;
  logic       busy;
  logic [7:0] overrun_count;

  modport master (
    output mag_in, mag_valid,
    input  level, level_valid, busy, overrun_count
  );

  modport slave (
    input  mag_in, mag_valid,
    output level, level_valid, busy, overrun_count
  );

endinterface

// File: rtl/mag_conditioner_ema_step.sv
// One noise-gated, asymmetric attack/decay smoothing step for a single bin.
module ema_step
  import mag_cond_pkg::*;
#(
  parameter int ATTACK_SHIFT = 1,
  parameter int DECAY_SHIFT  = 3,
  parameter int GATE         = 64
) (
  input  mag_t y,
  input  mag_t x,
  output mag_t y_next
);

  mag_t x_gated;
  mag_t step;

  // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
  always_comb begin
    x_gated = (x < mag_t'(GATE)) ? '0 : x;
    step    = '0;
    y_next  = y;
    if (x_gated > y) begin
      step   = (x_gated - y) >> ATTACK_SHIFT;
      y_next = y + ((step == '0) ? mag_t'(1) : step);
    end else if (x_gated < y) begin
      step   = (y - x_gated) >> DECAY_SHIFT;
      y_next = y - ((step == '0) ? mag_t'(1) : step);
    end
  end

endmodule

// File: rtl/mag_conditioner.sv
// Captures a magnitude frame, smooths one bin per clock through a shared ema_step,
// then publishes all levels together with a one-cycle strobe.
module mag_conditioner
  import mag_cond_pkg::*;
#(
  parameter int ATTACK_SHIFT = 1,
  parameter int DECAY_SHIFT  = 3,
  parameter int GATE         = 64
) (
  input logic         clk,
  input logic         reset,
  mag_conditioner_if.slave bus
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             publish;
  mag_t             snap [0:NBINS-1];
  mag_t             acc  [0:NBINS-1];
  mag_t             acc_next;

  ema_step #(
    .ATTACK_SHIFT(ATTACK_SHIFT),
    .DECAY_SHIFT (DECAY_SHIFT),
    .GATE        (GATE)
  ) u_step (
    .y     (acc[idx]),
    .x     (snap[idx]),
    .y_next(acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      publish <= 1'b0;
      // NOTE: acc/snap/level are cleared explicitly because the servos must start from 0 after reset.
      snap  <= '{default: '0};
      acc   <= '{default: '0};
      bus.level         <= '{default: '0};
      bus.level_valid   <= 1'b0;
      bus.busy          <= 1'b0;
      bus.overrun_count <= '0;
    end else begin
      // The level bus reloads only on publish, so servos see a stable value between strobes.
      bus.level_valid <= publish;
      publish         <= 1'b0;
      if (publish) begin
        bus.level <= acc;
      end

      if (bus.mag_valid && (state != IDLE) && (bus.overrun_count != 8'hFF)) begin
        bus.overrun_count <= bus.overrun_count + 8'd1;
      end

      unique case (state)
        IDLE: begin
          if (bus.mag_valid) begin
            snap     <= bus.mag_in;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc[idx] <= acc_next;
          idx      <= idx + IDX_W'(1);
          if (idx == IDX_W'(NBINS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          publish  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_conditioner.sv
// Randomised self-checking bench for mag_conditioner against an arithmetic smoothing model.
module tb_mag_conditioner;
  import mag_cond_pkg::*;

  localparam int ATTACK_SHIFT = 1;
  localparam int DECAY_SHIFT  = 3;
  localparam int GATE         = 64;
  localparam int LATENCY      = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mag_conditioner_if bus ();

  mag_conditioner #(
    .ATTACK_SHIFT(ATTACK_SHIFT),
    .DECAY_SHIFT (DECAY_SHIFT),
    .GATE        (GATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_acc [NBINS];
  int frame     [NBINS];

  // Smoothing rule expressed directly in integer arithmetic.
  function automatic int ref_next(int y, int x);
    int xg;
    int d;
    xg = (x < GATE) ? 0 : x;
    if (xg > y) begin
      d = (xg - y) / (2 ** ATTACK_SHIFT);
      return y + ((d < 1) ? 1 : d);
    end
    if (xg < y) begin
      d = (y - xg) / (2 ** DECAY_SHIFT);
      return y - ((d < 1) ? 1 : d);
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    bus.mag_valid = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    for (int i = 0; i < NBINS; i++) model_acc[i] = 0;
  endtask

  task automatic fill_frame(int value);
    for (int i = 0; i < NBINS; i++) frame[i] = value;
  endtask

  // Sends frame[], advances the model, and reports strobe latency and whether busy held.
  task automatic run_frame(output int lat, output bit busy_ok);
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = mag_t'(frame[i]);
    bus.mag_valid = 1'b1;
    tick();
    bus.mag_valid = 1'b0;
    for (int i = 0; i < NBINS; i++) model_acc[i] = ref_next(model_acc[i], frame[i]);
    lat = -1;
    busy_ok = bus.busy;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (bus.level_valid) lat = c;
      else if (c <= 16 && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mag_valid = 1'b1;
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = mag_t'(1000);
    tick();
    tick();
    n_checks++;
    if (bus.level_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b busy=%b ovr=%0d, required 0 0 0",
               bus.level_valid, bus.busy, bus.overrun_count);
    end
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(0)) begin
        n_fail++;
        $display("FAIL reset_level[%0d]: got %0d, required 0", i, bus.level[i]);
      end
    end
    reset = 1'b0;
    bus.mag_valid = 1'b0;
    for (int i = 0; i < NBINS; i++) model_acc[i] = 0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_valid: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_attack();
    int lat;
    bit busy_ok;
    do_reset(2);
    for (int f = 0; f < 2; f++) begin
      fill_frame(1000);
      run_frame(lat, busy_ok);
      n_checks++;
      if (lat !== LATENCY) begin
        n_fail++;
        $display("FAIL attack_latency%0d: got %0d, required %0d", f, lat, LATENCY);
      end
      for (int i = 0; i < NBINS; i++) begin
        n_checks++;
        if (bus.level[i] !== mag_t'(model_acc[i])) begin
          n_fail++;
          $display("FAIL attack_level%0d[%0d]: got %0d, required %0d", f, i, bus.level[i], model_acc[i]);
        end
      end
      tick();
      n_checks++;
      if (bus.level_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL attack_strobe_width%0d: valid=%b, required 0", f, bus.level_valid);
      end
    end
  endtask

  task automatic test_decay_gate();
    int lat;
    bit busy_ok;
    int guard;
    do_reset(2);
    fill_frame(1000);
    run_frame(lat, busy_ok);
    fill_frame(63);
    run_frame(lat, busy_ok);
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(model_acc[i])) begin
        n_fail++;
        $display("FAIL decay_gated[%0d]: got %0d, required %0d", i, bus.level[i], model_acc[i]);
      end
    end
    // Walk down to level 3, then take one min-step to 2.
    fill_frame(0);
    guard = 0;
    while (model_acc[0] > 3 && guard < 100) begin
      run_frame(lat, busy_ok);
      guard++;
    end
    for (int i = 0; i < NBINS; i++) frame[i] = (i % 2 == 0) ? 0 : 63;
    run_frame(lat, busy_ok);
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(model_acc[i])) begin
        n_fail++;
        $display("FAIL decay_min_step[%0d]: got %0d, required %0d", i, bus.level[i], model_acc[i]);
      end
    end
    fill_frame(0);
    guard = 0;
    while (model_acc[0] > 0 && guard < 10) begin
      run_frame(lat, busy_ok);
      guard++;
    end
    fill_frame(63);
    frame[5] = GATE;
    run_frame(lat, busy_ok);
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(model_acc[i])) begin
        n_fail++;
        $display("FAIL gate_boundary[%0d]: got %0d, required %0d", i, bus.level[i], model_acc[i]);
      end
    end
  endtask

  task automatic test_independence();
    int lat;
    bit busy_ok;
    do_reset(2);
    for (int i = 0; i < NBINS; i++) frame[i] = i * 200;
    run_frame(lat, busy_ok);
    n_checks++;
    if (busy_ok !== 1'b1 || lat !== LATENCY) begin
      n_fail++;
      $display("FAIL indep_busy_latency: busy_ok=%b lat=%0d, required 1 %0d", busy_ok, lat, LATENCY);
    end
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(i * 100)) begin
        n_fail++;
        $display("FAIL indep_level[%0d]: got %0d, required %0d", i, bus.level[i], i * 100);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    bit busy_ok;
    do_reset(2);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NBINS; i++) begin
        case ($urandom_range(0, 3))
          0: frame[i] = int'($urandom_range(0, GATE - 1));
          1: frame[i] = int'($urandom_range(GATE, 2000));
          2: frame[i] = int'($urandom_range(0, (1 << MAG_W) - 1));
          default: frame[i] = model_acc[i];
        endcase
      end
      run_frame(lat, busy_ok);
      n_checks++;
      if (lat !== LATENCY || busy_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL random_timing%0d: lat=%0d busy_ok=%b, required %0d 1", f, lat, busy_ok, LATENCY);
      end
      for (int i = 0; i < NBINS; i++) begin
        n_checks++;
        if (bus.level[i] !== mag_t'(model_acc[i])) begin
          n_fail++;
          $display("FAIL random_level%0d[%0d]: got %0d, required %0d", f, i, bus.level[i], model_acc[i]);
        end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_overrun();
    int pulses;
    int lat;
    do_reset(2);
    fill_frame(1000);
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = mag_t'(frame[i]);
    bus.mag_valid = 1'b1;
    tick();
    for (int i = 0; i < NBINS; i++) model_acc[i] = ref_next(model_acc[i], frame[i]);
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = mag_t'(5000 + i);
    pulses = 0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      bus.mag_valid = (c == 5 || c == 17);
      tick();
      if (bus.level_valid) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    bus.mag_valid = 1'b0;
    n_checks++;
    if (pulses !== 1 || lat !== LATENCY) begin
      n_fail++;
      $display("FAIL overrun_strobes: pulses=%0d lat=%0d, required 1 %0d", pulses, lat, LATENCY);
    end
    n_checks++;
    if (bus.overrun_count !== 8'd2) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d, required 2", bus.overrun_count);
    end
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(model_acc[i])) begin
        n_fail++;
        $display("FAIL overrun_level[%0d]: got %0d, required %0d", i, bus.level[i], model_acc[i]);
      end
    end
    bus.mag_valid = 1'b1;
    repeat (400) tick();
    bus.mag_valid = 1'b0;
    repeat (40) tick();
    n_checks++;
    if (bus.overrun_count !== 8'd255) begin
      n_fail++;
      $display("FAIL overrun_saturate: got %0d, required 255", bus.overrun_count);
    end
    do_reset(1);
    n_checks++;
    if (bus.overrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL overrun_reset: got %0d, required 0", bus.overrun_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    int lat;
    bit busy_ok;
    do_reset(2);
    fill_frame(700);
    run_frame(lat, busy_ok);
    fill_frame(1000);
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = mag_t'(frame[i]);
    bus.mag_valid = 1'b1;
    tick();
    bus.mag_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NBINS; i++) model_acc[i] = 0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.level_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_abort: pulses=%0d busy=%b, required 0 0", pulses, bus.busy);
    end
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(0)) begin
        n_fail++;
        $display("FAIL midrun_level[%0d]: got %0d, required 0", i, bus.level[i]);
      end
    end
    run_frame(lat, busy_ok);
    n_checks++;
    if (lat !== LATENCY) begin
      n_fail++;
      $display("FAIL midrun_restart_latency: got %0d, required %0d", lat, LATENCY);
    end
    for (int i = 0; i < NBINS; i++) begin
      n_checks++;
      if (bus.level[i] !== mag_t'(model_acc[i])) begin
        n_fail++;
        $display("FAIL midrun_restart[%0d]: got %0d, required %0d", i, bus.level[i], model_acc[i]);
      end
    end
  endtask

  initial begin
    bus.mag_valid = 1'b0;
    for (int i = 0; i < NBINS; i++) bus.mag_in[i] = '0;
    test_reset();
    test_attack();
    test_decay_gate();
    test_independence();
    test_random();
    test_overrun();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mag_conditioner.md
Name: mag_conditioner

Overview:
- Sits between the FFT magnitude stage and the 16 servo drivers.
- Captures a 16-bin magnitude frame on a one-cycle valid strobe.
- Processes one bin per clock:
  - applies a noise gate;
  - applies an asymmetric attack/decay exponential smoother, so servos track rises quickly and fall slowly instead of jittering.
- Publishes all 16 smoothed levels together with a one-cycle done strobe.

Parameters:
- NBINS, 16, number of frequency bins / servo channels
- MAG_W, 17, magnitude and level width in bits
- ATTACK_SHIFT, 1, right-shift applied to the rising error (larger is slower attack)
- DECAY_SHIFT, 3, right-shift applied to the falling error (larger is slower decay)
- GATE, 64, inputs strictly below this value are treated as 0

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mag_in  input  [MAG_W-1:0] x [0:NBINS-1]  raw bin magnitudes from the FFT stage
- mag_valid  input  1  one-cycle strobe: mag_in holds a complete new frame
- level  output  [MAG_W-1:0] x [0:NBINS-1]  smoothed levels to the servo inputs
- level_valid  output  1  one-cycle strobe: level just updated
- busy  output  1  high while a frame is being processed
- overrun_count  output  8  saturating count of frames dropped while busy

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset response: state IDLE, idx=0; all acc and level entries 0; level_valid=0, busy=0, overrun_count=0; capture register cleared.
- State machine (IDLE, RUN, DONE):
  - IDLE: if mag_valid, capture all mag_in into snap, set idx=0, go to RUN.
  - RUN: compute acc[idx] <= next(acc[idx], snap[idx]) and increment idx. When idx==NBINS-1, the last bin is written and the state goes to DONE.
  - DONE: level <= acc (all bins in one cycle), level_valid <= 1 for exactly one cycle, go to IDLE.
- busy is 1 in RUN and DONE, 0 in IDLE.
- Latency: mag_valid sampled at edge 0, RUN at edges 1..16, DONE at edge 17. level and level_valid are registered at edge 18, so level_valid is high in the cycle after edge 18. Minimum frame period is 19 clocks.
- next(y, x), computed with x' = (x < GATE) ? 0 : x:
  - x' > y: d = (x'-y) >> ATTACK_SHIFT; y + max(d, 1).
  - x' < y: d = (y-x') >> DECAY_SHIFT; y - max(d, 1).
  - x' == y: y unchanged.
  - The minimum step of 1 guarantees convergence to x'. The result never overshoots x', so it never exceeds 2^MAG_W-1 and needs no extra width.
- mag_valid while busy (including the DONE cycle): the frame is dropped and overrun_count increments, saturating at 255. acc, snap and level are unaffected.
- mag_valid in IDLE on the same cycle that DONE returns to IDLE: accepted normally, because DONE→IDLE takes effect at that edge.
- Reset mid-operation overrides everything:
  - RUN or DONE is aborted and no level_valid is produced;
  - all state returns to reset values.
- level is stable between level_valid strobes; the servo stage may sample it at any time.

Decomposition:
- Package mag_cond_pkg holds:
  - NBINS and MAG_W default constants;
  - state_t enum {IDLE, RUN, DONE};
  - mag_t typedef logic [MAG_W-1:0].
- One sub-module, ema_step: purely combinational next(y, x) with ATTACK_SHIFT, DECAY_SHIFT and GATE parameters. It is instantiated once and time-shared by idx, which keeps the datapath to a single subtractor/shifter pair.

Test Plan (default parameters):
- Reset:
  - assert reset 2 cycles -> all level=0, level_valid=0, busy=0, overrun_count=0;
  - mag_valid during reset is ignored.
- Attack and latency:
  - from reset, frame with all bins 1000 -> level_valid exactly 18 cycles after the mag_valid edge, all level=500;
  - second identical frame -> level=750.
- Decay, gate and min-step:
  - from level=500, frame of all 63 (gated to 0) -> level=438 (500-62);
  - bin at 3 with input 0 -> 2;
  - bin at 0 with input 63 -> stays 0.
- Per-bin independence: frame mag_in[i]=i*200 from reset -> level[i]=i*100 (bin 0 stays 0, gated); busy high throughout processing.
- Overrun:
  - mag_valid at cycles 0, 5 and 17 -> frames 2 and 3 dropped, overrun_count=2, one level_valid;
  - after 255 drops the count holds at 255.
- Reset mid-run: reset at cycle 8 after mag_valid -> no level_valid, level all 0, busy=0; the next frame then behaves as from reset.
